display_scan_controller: RTL
============================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000: clock cycles a digit is driven per visit (>=1).
REQ-002 Parameter BLANK_CYCLES, default 500: clock cycles of inter-digit ghost-suppression blanking (>=1).
REQ-003 clk  input  1  single system clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 upd_data  input  16  four BCD/hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-006 upd_blank  input  4  per-digit forced blank mask, bit i blanks digit i.
REQ-007 upd_valid  input  1  update request; transfer occurs when upd_valid && upd_ready.
REQ-008 upd_ready  output  1  staging register empty, update accepted.
REQ-009 binary_code  output  4  nibble to the shared 7-segment decoder.
REQ-010 decoder_enable  output  1  drives the decoder enable; low forces all segments off.
REQ-011 digit_select_n  output  4  active-low digit anode selects, at most one bit low.
REQ-012 frame_tick  output  1  one-cycle pulse at the end of every 4-digit frame.

Function
REQ-013 FSM states SHOW and BLANK; one down-counter and a 2-bit digit index idx.
REQ-014 BLANK: decoder_enable=0, digit_select_n=4'b1111; after BLANK_CYCLES cycles -> SHOW with counter loaded DWELL_CYCLES-1.
REQ-015 SHOW: digit_select_n has only bit idx low; binary_code = shadow nibble idx; decoder_enable=1 unless digit idx is blanked.
REQ-016 At SHOW counter expiry -> BLANK, idx increments modulo 4 (3 wraps to 0); digit period = BLANK_CYCLES+DWELL_CYCLES exactly.
REQ-017 frame_tick pulses in the cycle SHOW expires with idx=3.
REQ-018 Accepted update is captured into a staging register; upd_ready drops the next cycle.
REQ-019 Staging is copied to shadow only in the frame_tick cycle (no tearing); upd_ready returns high the following cycle.
REQ-020 upd_valid while upd_ready=0 is ignored; data is not held.
REQ-021 Transfer and commit in the same cycle: commit uses prior staging; new data stays pending for the next frame.
REQ-022 All outputs registered; binary_code and digit_select_n change in the same cycle.

Reset
REQ-023 On rst_n low, immediately: state BLANK, counter BLANK_CYCLES-1, idx 0, decoder_enable 0, digit_select_n 4'b1111, binary_code 0, frame_tick 0, upd_ready 1.
REQ-024 Reset clears shadow data to 0 and shadow blank mask to 4'b1111 (display dark until first commit); staging is emptied.
REQ-025 Reset mid-frame discards any pending update; the first cycle after release begins a full BLANK interval for digit 0.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN: when defined, digit i (i>=1) is also blanked if its shadow nibble and every more-significant nibble are zero; digit 0 is never blanked by this rule.
REQ-027 Without LEADING_ZERO_BLANK_EN only upd_blank controls blanking; zero nibbles display as "0".

Structure
REQ-028 Package display_pkg holds NUM_DIGITS=4, NIBBLE_W=4, the scan state enum, and the default DWELL/BLANK constants.
REQ-029 Sub-module display_scan_timer (loadable down-counter with expiry flag) is instantiated once; the decoder stays external.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=1)
REQ-030 Reset release, no update -> decoder_enable stays 0 for 40 cycles; digit_select_n cycles 1110,1101,1011,0111 with 1111 between; frame_tick every 20 cycles.
REQ-031 upd_data=16'h1234, upd_blank=0 mid-frame -> shadow unchanged until frame_tick; next frame shows 4,3,2,1 on digits 0-3; upd_ready high one cycle after the commit.
REQ-032 Second upd_valid while upd_ready=0 -> ignored; only the first value is ever displayed.
REQ-033 upd_data=16'h0050 with LEADING_ZERO_BLANK_EN -> digits 3,2 disabled, digits 1,0 show 5,0; without the macro all four enabled.
REQ-034 rst_n pulsed low during SHOW of digit 2 with an update pending -> outputs take reset values asynchronously; display dark afterwards; pending update lost.
REQ-035 Transfer in the frame_tick cycle -> old staging commits, new value commits at the following frame_tick.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, scan state encoding and frame payload for the 4-digit display scanner.
package display_pkg;

    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned NIBBLE_W      = 4;
    localparam int unsigned DATA_W        = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned DWELL_DEFAULT = 50000;
    localparam int unsigned BLANK_DEFAULT = 500;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] blank;
        logic [DATA_W-1:0]     data;
    } frame_t;

    // Digits 1..3 that are zero together with every more-significant digit; digit 0 never set.
    function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [DATA_W-1:0] data);
        logic [NUM_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (data[i*NIBBLE_W +: NIBBLE_W] == '0);
            mask[i]  = all_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Loadable down-counter that parks at zero; expired_c flags the final cycle of an interval.
module display_scan_timer
    import display_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             expired_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_W'(RESET_VALUE);
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit 7-segment scan controller with tear-free frame-synchronous updates.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DWELL_DEFAULT,
    parameter int unsigned BLANK_CYCLES = BLANK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     upd_data,
    input  logic [NUM_DIGITS-1:0] upd_blank,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    output logic [NIBBLE_W-1:0]   binary_code,
    output logic                  decoder_enable,
    output logic [NUM_DIGITS-1:0] digit_select_n,
    output logic                  frame_tick
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t           state, state_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic                  load_c;
    logic [CNT_W-1:0]      load_value_c;
    logic [CNT_W-1:0]      count;
    logic                  expired_c;
    logic                  last_next_c;
    logic [NUM_DIGITS-1:0] blank_eff_c;
    logic [NUM_DIGITS-1:0] select_next;
    logic                  enable_next;
    logic [NIBBLE_W-1:0]   code_next;
    logic                  tick_next;
    frame_t                staging;
    frame_t                shadow;

    display_scan_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (BLANK_CYCLES - 1)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .load_value (load_value_c),
        .count      (count),
        .expired_c  (expired_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_eff_c = shadow.blank | leading_zero_mask(shadow.data);
`else
    assign blank_eff_c = shadow.blank;
`endif

    // Next state plus next-cycle output values, so registered outputs line up with the state.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        load_c       = 1'b0;
        load_value_c = BLANK_LOAD;
        select_next  = '1;
        enable_next  = 1'b0;
        code_next    = '0;
        tick_next    = 1'b0;

        case (state)
            SCAN_BLANK: begin
                if (expired_c) begin
                    state_next   = SCAN_SHOW;
                    load_c       = 1'b1;
                    load_value_c = DWELL_LOAD;
                end
            end
            SCAN_SHOW: begin
                if (expired_c) begin
                    state_next   = SCAN_BLANK;
                    idx_next     = idx + IDX_W'(1);
                    load_c       = 1'b1;
                    load_value_c = BLANK_LOAD;
                end
            end
            default: begin
                state_next = SCAN_BLANK;
            end
        endcase

        // True when the counter will read zero in the coming cycle.
        last_next_c = load_c ? (load_value_c == '0) : (count == CNT_W'(1));

        if (state_next == SCAN_SHOW) begin
            select_next = ~(NUM_DIGITS'(1) << idx_next);
            enable_next = ~blank_eff_c[idx_next];
            code_next   = NIBBLE_W'(shadow.data >> (NIBBLE_W * 32'(idx_next)));
            tick_next   = last_next_c && (idx_next == LAST_IDX);
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SCAN_BLANK;
            idx            <= '0;
            digit_select_n <= '1;
            decoder_enable <= 1'b0;
            binary_code    <= '0;
            frame_tick     <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            digit_select_n <= select_next;
            decoder_enable <= enable_next;
            binary_code    <= code_next;
            frame_tick     <= tick_next;
        end
    end

    // upd_ready doubles as the staging-empty flag; commit only on the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_ready <= 1'b1;
            staging   <= '{blank: '1, data: '0};
            shadow    <= '{blank: '1, data: '0};
        end else if (frame_tick && !upd_ready) begin
            shadow    <= staging;
            upd_ready <= 1'b1;
        end else if (upd_valid && upd_ready) begin
            staging   <= '{blank: upd_blank, data: upd_data};
            upd_ready <= 1'b0;
        end
    end

endmodule
